// File: rtl/slv_i2c_pkg.sv
// Shared definitions for the I2C register-access slave: one-hot FSM encoding,
// counter sizing and the position of the R/W flag in the address byte.
package slv_i2c_pkg;

  typedef enum logic [8:0] {
    IDLE     = 9'b0_0000_0001,
    ADDR     = 9'b0_0000_0010,
    ACK_ADDR = 9'b0_0000_0100,
    PTR      = 9'b0_0000_1000,
    ACK_PTR  = 9'b0_0001_0000,
    RX       = 9'b0_0010_0000,
    ACK_RX   = 9'b0_0100_0000,
    TX       = 9'b0_1000_0000,
    MACK     = 9'b1_0000_0000
  } state_t;

  localparam int RW_BIT = 0;

  // Counter must hold the full byte length, not just DATA_SZ-1.
  function automatic int cnt_width(input int data_sz);
    return $clog2(data_sz + 1);
  endfunction

endpackage

// File: rtl/slv_i2c_reg_core_if.sv
// Bus-side and register-file-side signals of the I2C slave core.
interface slv_i2c_reg_core_if #(
  parameter int DATA_SZ = 8,
  parameter int N_REG   = 16
);
  localparam int PTR_SZ = $clog2(N_REG);

  logic               I_SCL;
  logic               I_SDA;
  logic               I_RS_IO_SCL;
  logic               I_FL_IO_SCL;
  logic               I_RS_IO_SDA;
  logic               I_FL_IO_SDA;
  logic               I_MDL_LW_IO_SCL;
  logic [DATA_SZ-1:0] I_RD_DATA;
  logic               O_SDA;
  logic               O_BUSY;
  logic [PTR_SZ-1:0]  O_REG_ADDR;
  logic [DATA_SZ-1:0] O_WR_DATA;
  logic               O_WR_EN;
  logic               O_RD_EN;
  logic               O_ACK_MSTR;

  modport slave (
    input  I_SCL, I_SDA, I_RS_IO_SCL, I_FL_IO_SCL, I_RS_IO_SDA, I_FL_IO_SDA,
           I_MDL_LW_IO_SCL, I_RD_DATA,
    output O_SDA, O_BUSY, O_REG_ADDR, O_WR_DATA, O_WR_EN, O_RD_EN, O_ACK_MSTR
  );

  modport master (
    output I_SCL, I_SDA, I_RS_IO_SCL, I_FL_IO_SCL, I_RS_IO_SDA, I_FL_IO_SDA,
           I_MDL_LW_IO_SCL, I_RD_DATA,
    input  O_SDA, O_BUSY, O_REG_ADDR, O_WR_DATA, O_WR_EN, O_RD_EN, O_ACK_MSTR
  );
endinterface

// File: rtl/slv_i2c_shift.sv
// Bidirectional byte shift register with its bit counter; shared by receive
// (serial in, MSB first) and transmit (serial out from MSB) paths.
module slv_i2c_shift #(
  parameter int DATA_SZ = 8,
  parameter int CNT_SZ  = 4
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               load,
  input  logic [DATA_SZ-1:0] load_data,
  input  logic               shift_in,
  input  logic               sda_in,
  input  logic               shift_out,
  input  logic               cnt_set,
  input  logic [CNT_SZ-1:0]  cnt_val,
  output logic [DATA_SZ-1:0] shreg,
  output logic [CNT_SZ-1:0]  cnt
);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (load)
        shreg <= load_data;
      else if (shift_in)
        shreg <= {shreg[DATA_SZ-2:0], sda_in};
      else if (shift_out)
        shreg <= {shreg[DATA_SZ-2:0], 1'b0};

      // A set wins over the decrement so the first transmitted bit can reload it.
      if (cnt_set)
        cnt <= cnt_val;
      else if ((shift_in || shift_out) && cnt != '0)
        cnt <= cnt - CNT_SZ'(1);
    end
  end

endmodule

// File: rtl/slv_i2c_reg_core.sv
// I2C slave front end exposing a register file: pointer byte, auto-incrementing
// burst writes and reads, ACK generation and master-ACK capture.
module slv_i2c_reg_core
  import slv_i2c_pkg::*;
#(
  parameter int         DATA_SZ  = 8,
  parameter logic [6:0] ADDR_SLV = 7'h50,
  parameter int         N_REG    = 16
) (
  input  logic                CLK,
  input  logic                RST_n,
  slv_i2c_reg_core_if.slave   bus
);

  localparam int PTR_SZ = $clog2(N_REG);
  localparam int CNT_SZ = cnt_width(DATA_SZ);

  state_t              state;
  logic [CNT_SZ-1:0]   cnt;
  logic [DATA_SZ-1:0]  shreg;
  logic [PTR_SZ-1:0]   ptr_q, ptr_nxt;
  logic [DATA_SZ-1:0]  wr_data_q;
  logic                sda_q, busy_q, wr_en_q, rd_en_q, ack_q;
  logic                matched, rw, rd_pend;
  logic                start_c, stop_c, mdl, addr_hit;
  logic                sh_in, sh_out, cnt_set;
  logic [CNT_SZ-1:0]   cnt_val;
  logic                unused_fl_scl;

  assign start_c       = bus.I_FL_IO_SDA & bus.I_SCL;
  assign stop_c        = bus.I_RS_IO_SDA & bus.I_SCL;
  assign mdl           = bus.I_MDL_LW_IO_SCL;
  assign addr_hit      = (shreg[DATA_SZ-1 -: 7] == ADDR_SLV);
  assign ptr_nxt       = (ptr_q == PTR_SZ'(N_REG - 1)) ? '0 : ptr_q + PTR_SZ'(1);
  assign unused_fl_scl = bus.I_FL_IO_SCL;

  assign bus.O_SDA      = sda_q;
  assign bus.O_BUSY     = busy_q;
  assign bus.O_REG_ADDR = ptr_q;
  assign bus.O_WR_DATA  = wr_data_q;
  assign bus.O_WR_EN    = wr_en_q;
  assign bus.O_RD_EN    = rd_en_q;
  assign bus.O_ACK_MSTR = ack_q;

  always_comb begin
    sh_in   = 1'b0;
    sh_out  = 1'b0;
    cnt_set = 1'b0;
    cnt_val = '0;
    if (stop_c) begin
      cnt_set = 1'b0;
    end else if (start_c) begin
      cnt_set = 1'b1;
      cnt_val = CNT_SZ'(DATA_SZ);
    end else begin
      unique case (state)
        ADDR, PTR, RX: sh_in = bus.I_RS_IO_SCL && (cnt != '0);
        ACK_ADDR: if (mdl && matched) begin
          sh_out  = rw;
          cnt_set = 1'b1;
          cnt_val = rw ? CNT_SZ'(DATA_SZ - 1) : CNT_SZ'(DATA_SZ);
        end
        ACK_PTR, ACK_RX: if (mdl) begin
          cnt_set = 1'b1;
          cnt_val = CNT_SZ'(DATA_SZ);
        end
        TX:   sh_out = mdl && (cnt != '0);
        MACK: if (mdl && !ack_q && !bus.I_RS_IO_SCL) begin
          sh_out  = 1'b1;
          cnt_set = 1'b1;
          cnt_val = CNT_SZ'(DATA_SZ - 1);
        end
        default: cnt_set = 1'b0;
      endcase
    end
  end

  slv_i2c_shift #(.DATA_SZ(DATA_SZ), .CNT_SZ(CNT_SZ)) u_shift (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .load      (rd_pend),
    .load_data (bus.I_RD_DATA),
    .shift_in  (sh_in),
    .sda_in    (bus.I_SDA),
    .shift_out (sh_out),
    .cnt_set   (cnt_set),
    .cnt_val   (cnt_val),
    .shreg     (shreg),
    .cnt       (cnt)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ack_q     <= 1'b1;
      ptr_q     <= '0;
      wr_data_q <= '0;
      matched   <= 1'b0;
      rw        <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_pend <= rd_en_q;
      if (stop_c) begin
        state  <= IDLE;
        sda_q  <= 1'b1;
        busy_q <= 1'b0;
      end else if (start_c) begin
        state <= ADDR;
        sda_q <= 1'b1;
      end else begin
        unique case (state)
          IDLE: sda_q <= 1'b1;
          ADDR: if (mdl && cnt == '0) begin
            state   <= ACK_ADDR;
            matched <= addr_hit;
            rw      <= shreg[RW_BIT];
            sda_q   <= ~addr_hit;
            busy_q  <= addr_hit;
            rd_en_q <= addr_hit & shreg[RW_BIT];
          end
          ACK_ADDR: if (mdl) begin
            if (!matched) begin
              state <= IDLE;
              sda_q <= 1'b1;
            end else if (rw) begin
              state <= TX;
              sda_q <= shreg[DATA_SZ-1];
            end else begin
              state <= PTR;
              sda_q <= 1'b1;
            end
          end
          PTR: if (mdl && cnt == '0) begin
            state <= ACK_PTR;
            ptr_q <= PTR_SZ'(int'(shreg) % N_REG);
            sda_q <= 1'b0;
          end
          ACK_PTR: if (mdl) begin
            state <= RX;
            sda_q <= 1'b1;
          end
          RX: if (mdl && cnt == '0) begin
            state     <= ACK_RX;
            wr_data_q <= shreg;
            wr_en_q   <= 1'b1;
            sda_q     <= 1'b0;
          end
          ACK_RX: if (mdl) begin
            state <= RX;
            sda_q <= 1'b1;
            ptr_q <= ptr_nxt;
          end
          TX: if (mdl) begin
            if (cnt != '0) begin
              sda_q <= shreg[DATA_SZ-1];
            end else begin
              state <= MACK;
              sda_q <= 1'b1;
            end
          end
          // Prefetch on the ACK clock so the next byte is ready by mid-low.
          MACK: begin
            if (bus.I_RS_IO_SCL) begin
              ack_q <= bus.I_SDA;
              if (!bus.I_SDA) begin
                ptr_q   <= ptr_nxt;
                rd_en_q <= 1'b1;
              end
            end else if (mdl) begin
              if (!ack_q) begin
                state <= TX;
                sda_q <= shreg[DATA_SZ-1];
              end else begin
                state <= IDLE;
                sda_q <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            sda_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
